fire_sequencer: RTL

FIRE_SEQUENCER -- requirements
Module: fire_sequencer

---
 rtl/fire_pkg.sv | 29 ++
 rtl/period_timer.sv | 72 +++++++
 rtl/fire_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fire_pkg.sv
// Shared definitions for the transducer fire sequencer: defaults, tick size, state encoding.
// Latency: none (declarations and a pure combinational helper only).
// Backpressure: not applicable.
package fire_pkg;

    localparam int NCH_DEF = 4;   // transducer channels in this release
    localparam int CW_DEF  = 20;  // cycle field width, in ticks
    localparam int PW_DEF  = 12;  // pulse field width, in ticks
    localparam int TICK_NS = 10;  // one tick of the 100 MHz system clock

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Lowest enabled channel whose index is >= from; bit 2 flags that one was found.
    function automatic logic [2:0] find_next_ch(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/period_timer.sv
// Period counter (1..cycle, wrapping) with registered fire and capture-window outputs.
// Latency: fire/cap_win reflect the counter value of the previous clock (one register stage).
// Backpressure: none; i_gate low clears both outputs on the next edge.
module period_timer
    import fire_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_run,
    input  logic          i_gate,
    input  logic [CW-1:0] i_cycle,
    input  logic [PW-1:0] i_pulse,
    input  logic [15:0]   i_cap_dly,
    input  logic [15:0]   i_cap_len,
    output logic          o_end,
    output logic          o_fire,
    output logic          o_cap_win
);

    // Comparisons run at a common width of at least 17 bits so dly+len never wraps.
    localparam int WA = (CW > PW) ? CW : PW;
    localparam int WW = (WA > 17) ? WA : 17;

    logic [CW-1:0] r_cnt;
    logic          r_fire;
    logic          r_cap_win;

    logic [WW-1:0] w_cnt_x;
    logic [WW-1:0] w_win_lo;
    logic [WW-1:0] w_win_hi;
    logic          w_fire_hit;
    logic          w_win_hit;

    assign w_cnt_x    = WW'(r_cnt);
    assign w_win_lo   = WW'(i_cap_dly) + WW'(1);
    assign w_win_hi   = WW'(i_cap_dly) + WW'(i_cap_len);
    assign w_fire_hit = (r_cnt != '0) && (w_cnt_x <= WW'(i_pulse));
    // Window is clipped at the end of the period; a zero length opens no window.
    assign w_win_hit  = (i_cap_len != 16'd0) && (w_cnt_x >= w_win_lo) &&
                        (w_cnt_x <= w_win_hi) && (w_cnt_x <= WW'(i_cycle));
    assign o_end      = (r_cnt == i_cycle);

    // Period counter: loaded with 1 on channel select, counts 1..cycle while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(1);
        end else if (i_run) begin
            r_cnt <= o_end ? CW'(1) : r_cnt + CW'(1);
        end
    end

    // Registered fire and capture gate, forced low whenever the gate is withdrawn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fire    <= 1'b0;
            r_cap_win <= 1'b0;
        end else begin
            r_fire    <= i_gate && w_fire_hit;
            r_cap_win <= i_gate && w_win_hit;
        end
    end

    assign o_fire    = r_fire;
    assign o_cap_win = r_cap_win;

endmodule

// File: rtl/fire_sequencer.sv
// Scan sequencer: walks enabled channels in ascending order, firing 'shots' periods on each.
// Latency: first fire high 2 clocks after the accepting edge; done/cfg_err/busy registered.
// Backpressure: start ignored while busy; stop aborts to IDLE on the next edge.
module fire_sequencer
    import fire_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic [CW-1:0]  cycle,
    input  logic [PW-1:0]  pulse,
    input  logic [15:0]    cap_dly,
    input  logic [15:0]    cap_len,
    input  logic [15:0]    shots,
    input  logic [NCH-1:0] ch_mask,
    output logic           fire,
    output logic [1:0]     ch_sel,
    output logic           cap_win,
    output logic           busy,
    output logic           done,
    output logic           cfg_err,
    output logic [15:0]    shot_cnt
);

    localparam int WA = (CW > PW) ? CW : PW;

    state_t         r_state;
    state_t         w_next;

    logic [CW-1:0]  r_cycle;
    logic [PW-1:0]  r_pulse;
    logic [15:0]    r_cap_dly;
    logic [15:0]    r_cap_len;
    logic [15:0]    r_shots;
    logic [NCH-1:0] r_mask;
    logic           r_first;
    logic [1:0]     r_ch;
    logic [15:0]    r_shot_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_cfg_err;

    logic           w_bad;
    logic [2:0]     w_from;
    logic [2:0]     w_srch;
    logic           w_last;
    logic           w_end;
    logic           w_load;
    logic           w_run;
    logic           w_gate;
    logic           w_accept;
    logic           w_cerr_nxt;
    logic           w_done_nxt;
    logic           w_shot_inc;

    assign w_bad  = (ch_mask == '0) || (pulse == '0) ||
                    (WA'(pulse) >= WA'(cycle)) || (cycle < CW'(2));
    // The first select searches from channel 0; later searches start above the current one.
    assign w_from = (r_state == ST_SELECT && r_first) ? 3'd0 : ({1'b0, r_ch} + 3'd1);
    assign w_srch = find_next_ch(4'(r_mask), w_from);
    assign w_last = ((r_shot_cnt + 16'd1) == r_shots);

    period_timer #(
        .CW(CW),
        .PW(PW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_run     (w_run),
        .i_gate    (w_gate),
        .i_cycle   (r_cycle),
        .i_pulse   (r_pulse),
        .i_cap_dly (r_cap_dly),
        .i_cap_len (r_cap_len),
        .o_end     (w_end),
        .o_fire    (fire),
        .o_cap_win (cap_win)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; stop wins over a simultaneous period end.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start && !w_bad) w_next = ST_SELECT;
            ST_SELECT: w_next = stop ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (stop)                 w_next = ST_IDLE;
                else if (w_end && w_last) w_next = w_srch[2] ? ST_SELECT : ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output/control decode from the current state and inputs.
    always_comb begin
        w_load     = (r_state == ST_SELECT);
        w_run      = (r_state == ST_RUN);
        w_gate     = (r_state == ST_RUN) && !stop;
        w_accept   = (r_state == ST_IDLE) && start && !w_bad;
        w_cerr_nxt = (r_state == ST_IDLE) && start && w_bad;
        w_shot_inc = (r_state == ST_RUN) && !stop && w_end;
        w_done_nxt = w_shot_inc && w_last && !w_srch[2];
    end

    // Scan configuration, captured once per accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_pulse   <= '0;
            r_cap_dly <= '0;
            r_cap_len <= '0;
            r_shots   <= '0;
            r_mask    <= '0;
        end else if (w_accept) begin
            r_cycle   <= cycle;
            r_pulse   <= pulse;
            r_cap_dly <= cap_dly;
            r_cap_len <= cap_len;
            r_shots   <= (shots == 16'd0) ? 16'd1 : shots;
            r_mask    <= ch_mask;
        end
    end

    // Channel selection and per-channel shot counting; shot_cnt holds once idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first    <= 1'b0;
            r_ch       <= 2'd0;
            r_shot_cnt <= 16'd0;
        end else if (w_accept) begin
            r_first    <= 1'b1;
            r_shot_cnt <= 16'd0;
        end else if (w_load) begin
            r_first    <= 1'b0;
            r_ch       <= w_srch[1:0];
            r_shot_cnt <= 16'd0;
        end else if (w_shot_inc) begin
            r_shot_cnt <= r_shot_cnt + 16'd1;
        end
    end

    // Registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= w_done_nxt;
            r_cfg_err <= w_cerr_nxt;
        end
    end

    assign ch_sel   = r_ch;
    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;
    assign shot_cnt = r_shot_cnt;

endmodule
